// File: rtl/xlr8_clken_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : xlr8_clken_if                                              |
// | Purpose  : Data-memory register bus between the AVR core (master)     |
// |            and the clock-enable block (slave).                        |
// | Signals  : ramadr   [7:0] data-memory address                         |
// |            ramre          read strobe                                 |
// |            ramwe          write strobe                                |
// |            dm_sel         data-memory select, qualifies ramre/ramwe   |
// |            dbus_in  [7:0] write data (master -> slave)                |
// |            dbus_out [7:0] read data  (slave -> master)                |
// |            io_out_en      slave is driving read data                  |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
interface xlr8_clken_if;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic       dm_sel;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       io_out_en;

  modport master (
    output ramadr, ramre, ramwe, dm_sel, dbus_in,
    input  dbus_out, io_out_en
  );

  modport slave (
    input  ramadr, ramre, ramwe, dm_sel, dbus_in,
    output dbus_out, io_out_en
  );
endinterface
`default_nettype wire

// File: rtl/xlr8_clken.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : xlr8_clken                                                 |
// | Purpose  : Generates a 1MHz and a 16MHz enable pulse from clk_cpu and |
// |            NUM_CH programmable channel enables, each firing once per  |
// |            (div+1) 1MHz periods. Registers CTRL/SEL/DIV live in data  |
// |            memory at BASE_ADDR..BASE_ADDR+2; DIV is indirect via SEL. |
// | Params   : CLOCK_SELECT 0=16MHz 1=32MHz 2=64MHz clk_cpu (3 illegal)   |
// |            NUM_CH       channel count, 1..8                           |
// |            BASE_ADDR    address of CTRL, 8'h60..8'hFD                 |
// | Ports    : clk_cpu      core clock, rising edge                       |
// |            core_rstn    asynchronous active-low reset                 |
// |            bus          register bus (slave modport)                  |
// |            en1mhz       one-cycle pulse at 1MHz                       |
// |            en16mhz      one-cycle pulse at 16MHz                      |
// |            ch_en_out    per-channel one-cycle enable pulses           |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module xlr8_clken #(
  parameter int         CLOCK_SELECT = 0,
  parameter int         NUM_CH       = 4,
  parameter logic [7:0] BASE_ADDR    = 8'hE0
) (
  input  wire               clk_cpu,
  input  wire               core_rstn,
  xlr8_clken_if.slave       bus,
  output logic              en1mhz,
  output logic              en16mhz,
  output logic [NUM_CH-1:0] ch_en_out
);

  localparam int         W         = CLOCK_SELECT + 4;
  localparam logic [7:0] ADDR_CTRL = BASE_ADDR;
  localparam logic [7:0] ADDR_SEL  = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_DIV  = BASE_ADDR + 8'd2;

  logic [W-1:0]            base_q, base_d;
  logic                    en1_q, en1_d;
  logic [NUM_CH-1:0]       ctrl_q, ctrl_d;
  logic [2:0]              sel_q;
  logic [NUM_CH-1:0][7:0]  div_all;
  logic [7:0]              div_rd;

  logic hit_ctrl, hit_sel, hit_div;
  logic wr_ctrl, wr_sel, wr_div;
  logic sel_valid;

  // ---------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------
  assign hit_ctrl  = bus.dm_sel && (bus.ramadr == ADDR_CTRL);
  assign hit_sel   = bus.dm_sel && (bus.ramadr == ADDR_SEL);
  assign hit_div   = bus.dm_sel && (bus.ramadr == ADDR_DIV);
  assign wr_ctrl   = hit_ctrl && bus.ramwe;
  assign wr_sel    = hit_sel  && bus.ramwe;
  assign sel_valid = int'(sel_q) < NUM_CH;
  assign wr_div    = hit_div && bus.ramwe && sel_valid;

  // Next CTRL value; the channels look at it so a disabling write wins
  // over a reload happening on the same edge.
  assign ctrl_d = wr_ctrl ? bus.dbus_in[NUM_CH-1:0] : ctrl_q;

  // ---------------------------------------------------------------------
  // Base counter: 2^W cycles per 1MHz period
  // ---------------------------------------------------------------------
  always_comb begin
    base_d = base_q - W'(1);
    en1_d  = 1'b0;
    if (base_q == '0) begin
      base_d = '1;
      en1_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) begin
      base_q <= '0;
      en1_q  <= 1'b0;
      ctrl_q <= '0;
      sel_q  <= '0;
    end else begin
      base_q <= base_d;
      en1_q  <= en1_d;
      ctrl_q <= ctrl_d;
      if (wr_sel) begin
        sel_q <= bus.dbus_in[2:0];
      end
    end
  end

  assign en1mhz = en1_q;

  // ---------------------------------------------------------------------
  // 16MHz enable: at a 16MHz core clock every cycle qualifies, so it is
  // simply "out of reset"; faster clocks decode the base counter low bits.
  // ---------------------------------------------------------------------
  if (CLOCK_SELECT == 0) begin : g_en16_const
    assign en16mhz = core_rstn;
  end else begin : g_en16_div
    logic en16_q;
    always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn) begin
        en16_q <= 1'b0;
      end else begin
        en16_q <= (base_q[CLOCK_SELECT-1:0] == '0);
      end
    end
    assign en16mhz = en16_q;
  end

  // ---------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [2:0] IDX = 3'(gi);

    logic [7:0] div_q;
    logic [7:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;
    logic       run;

    // Running only while enabled now and not being disabled this edge.
    assign run = ctrl_q[gi] && ctrl_d[gi];

    always_comb begin
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!run) begin
        cnt_d = '0;
      end else if (en1_q) begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;   // old div value if DIV is written this edge
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    end

    always_ff @(posedge clk_cpu or negedge core_rstn) begin
      if (!core_rstn) begin
        div_q   <= '0;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        if (wr_div && (sel_q == IDX)) begin
          div_q <= bus.dbus_in;
        end
      end
    end

    assign div_all[gi]   = div_q;
    assign ch_en_out[gi] = pulse_q;
  end

  // ---------------------------------------------------------------------
  // Read mux (combinational)
  // ---------------------------------------------------------------------
  always_comb begin
    div_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel_q) == i) begin
        div_rd = div_all[i];
      end
    end
  end

  always_comb begin
    bus.dbus_out  = '0;
    bus.io_out_en = 1'b0;
    if (bus.ramre) begin
      if (hit_ctrl) begin
        bus.dbus_out  = 8'(ctrl_q);
        bus.io_out_en = 1'b1;
      end else if (hit_sel) begin
        bus.dbus_out  = {5'd0, sel_q};
        bus.io_out_en = 1'b1;
      end else if (hit_div) begin
        bus.dbus_out  = div_rd;
        bus.io_out_en = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xlr8_clken.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_xlr8_clken                                              |
// | Purpose  : Self-checking bench for xlr8_clken. A CLOCK_SELECT=0 DUT   |
// |            carries the register and channel tests; a CLOCK_SELECT=2   |
// |            DUT shares clock and reset to check the base enables.      |
// |            Channel pulses are predicted into a scoreboard queue when  |
// |            configured and popped when the monitor sees the cycle.     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_xlr8_clken;

  localparam logic [7:0] ADDR_CTRL = 8'hE0;
  localparam logic [7:0] ADDR_SEL  = 8'hE1;
  localparam logic [7:0] ADDR_DIV  = 8'hE2;

  typedef struct {
    int         cyc;
    logic [3:0] bits;
  } exp_t;

  logic       clk_cpu;
  logic       core_rstn;
  logic       en1mhz, en16mhz;
  logic [3:0] ch_en_out;
  logic       en1mhz_2, en16mhz_2;
  logic [3:0] ch_en_out_2;

  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  logic [7:0] rd_q[$];
  exp_t mon_e;

  xlr8_clken_if bif();
  xlr8_clken_if bif2();

  xlr8_clken #(.CLOCK_SELECT(0), .NUM_CH(4), .BASE_ADDR(8'hE0)) u_dut (
    .clk_cpu   (clk_cpu),
    .core_rstn (core_rstn),
    .bus       (bif),
    .en1mhz    (en1mhz),
    .en16mhz   (en16mhz),
    .ch_en_out (ch_en_out)
  );

  xlr8_clken #(.CLOCK_SELECT(2), .NUM_CH(4), .BASE_ADDR(8'hE0)) u_dut_cs2 (
    .clk_cpu   (clk_cpu),
    .core_rstn (core_rstn),
    .bus       (bif2),
    .en1mhz    (en1mhz_2),
    .en16mhz   (en16mhz_2),
    .ch_en_out (ch_en_out_2)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  // Cycle index: 1 on the first rising edge after reset release.
  always @(posedge clk_cpu or negedge core_rstn) begin
    if (!core_rstn) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d, t=%0t)", tag, obs, exp, cyc, $time);
    end
  endtask

  // Monitor: base enables from closed-form timing, channel pulses from the
  // scoreboard queue.
  always @(negedge clk_cpu) begin
    if (!core_rstn) begin
      check_eq("rst_en1mhz",  {31'd0, en1mhz},   32'd0);
      check_eq("rst_en16mhz", {31'd0, en16mhz},  32'd0);
      check_eq("rst_ch",      {28'd0, ch_en_out}, 32'd0);
      check_eq("rst_en1_cs2", {31'd0, en1mhz_2}, 32'd0);
      check_eq("rst_en16_cs2",{31'd0, en16mhz_2},32'd0);
    end else begin
      check_eq("en1mhz",      {31'd0, en1mhz},   {31'd0, (cyc % 16) == 1});
      check_eq("en16mhz",     {31'd0, en16mhz},  32'd1);
      check_eq("en1mhz_cs2",  {31'd0, en1mhz_2}, {31'd0, (cyc % 64) == 1});
      check_eq("en16mhz_cs2", {31'd0, en16mhz_2},{31'd0, (cyc % 4) == 1});
      check_eq("ch_cs2_idle", {28'd0, ch_en_out_2}, 32'd0);
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        check_eq("ch_pulse", {28'd0, ch_en_out}, {28'd0, mon_e.bits});
      end else begin
        check_eq("ch_idle", {28'd0, ch_en_out}, 32'd0);
      end
    end
  end

  task automatic bus_idle();
    bif.ramadr = '0; bif.ramre = 1'b0; bif.ramwe = 1'b0;
    bif.dm_sel = 1'b0; bif.dbus_in = '0;
  endtask

  // Write lands on the edge that makes cyc == w.
  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data, output int w);
    @(negedge clk_cpu);
    bif.dm_sel = 1'b1; bif.ramwe = 1'b1; bif.ramadr = addr; bif.dbus_in = data;
    w = cyc + 1;
    #1;
    check_eq("wr_ioen", {31'd0, bif.io_out_en}, 32'd0);
    check_eq("wr_dbus", {24'd0, bif.dbus_out},  32'd0);
    @(negedge clk_cpu);
    bus_idle();
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    rd_q.push_back(exp);
    @(negedge clk_cpu);
    bif.dm_sel = 1'b1; bif.ramre = 1'b1; bif.ramadr = addr;
    #1;
    check_eq(tag, {24'd0, bif.dbus_out}, {24'd0, rd_q.pop_front()});
    check_eq({tag, "_ioen"}, {31'd0, bif.io_out_en}, 32'd1);
    bus_idle();
    #1;
    check_eq({tag, "_ioen_off"}, {31'd0, bif.io_out_en}, 32'd0);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_cpu);
  endtask

  function automatic int next_en1(input int w);
    int e;
    e = w;
    while ((e % 16) != 1) e++;
    return e;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, e;
    logic [3:0] b;
    n_checks = 0;
    n_errors = 0;
    core_rstn = 1'b0;
    bus_idle();
    bif2.ramadr = '0; bif2.ramre = 1'b0; bif2.ramwe = 1'b0;
    bif2.dm_sel = 1'b0; bif2.dbus_in = '0;

    repeat (3) @(negedge clk_cpu);
    check_eq("rst_dbus", {24'd0, bif.dbus_out},  32'd0);
    check_eq("rst_ioen", {31'd0, bif.io_out_en}, 32'd0);
    #2 core_rstn = 1'b1;

    // Reset values and register masking
    bus_read(ADDR_CTRL, 8'h00, "ctrl_rst");
    bus_read(ADDR_SEL,  8'h00, "sel_rst");
    bus_read(ADDR_DIV,  8'h00, "div_rst");
    bus_write(ADDR_CTRL, 8'hF0, w);
    bus_read(ADDR_CTRL, 8'h00, "ctrl_mask");
    bus_write(ADDR_SEL, 8'hFF, w);
    bus_write(ADDR_DIV, 8'h55, w);
    bus_read(ADDR_DIV, 8'h00, "div_oob");
    bus_read(ADDR_SEL, 8'h07, "sel_mask");
    for (int i = 0; i < 4; i++) begin
      bus_write(ADDR_SEL, 8'(i), w);
      bus_read(ADDR_DIV, 8'h00, "div_untouched");
    end

    // Reads that must not be claimed
    @(negedge clk_cpu);
    bif.ramre = 1'b1; bif.dm_sel = 1'b0; bif.ramadr = ADDR_CTRL;
    #1 check_eq("nosel_ioen", {31'd0, bif.io_out_en}, 32'd0);
    bif.dm_sel = 1'b1; bif.ramadr = ADDR_DIV + 8'd1;
    #1 check_eq("noaddr_ioen", {31'd0, bif.io_out_en}, 32'd0);
    check_eq("noaddr_dbus", {24'd0, bif.dbus_out}, 32'd0);
    bus_idle();

    // Channel 0, div=4: period 80 cycles, one cycle after en1mhz
    bus_write(ADDR_SEL, 8'h00, w);
    bus_write(ADDR_DIV, 8'h04, w);
    bus_write(ADDR_CTRL, 8'h01, w);
    e = next_en1(w);
    for (int k = 0; k < 3; k++) sb_q.push_back('{e + 1 + 80 * k, 4'b0001});
    wait_until(e + 170);
    bus_read(ADDR_DIV,  8'h04, "div0_rb");
    bus_read(ADDR_CTRL, 8'h01, "ctrl_rb");
    bus_write(ADDR_CTRL, 8'h00, w);

    // Channel 1, div=9: disable mid-count, re-enable, disable on en1mhz
    bus_write(ADDR_SEL, 8'h01, w);
    bus_write(ADDR_DIV, 8'h09, w);
    bus_write(ADDR_CTRL, 8'h02, w);
    e = next_en1(w);
    sb_q.push_back('{e + 1, 4'b0010});
    wait_until(e + 41);
    bus_write(ADDR_CTRL, 8'h00, w);
    wait_until(w + 200);
    bus_write(ADDR_CTRL, 8'h02, w);
    e = next_en1(w);
    sb_q.push_back('{e + 1, 4'b0010});
    wait_until(e + 159);
    bus_write(ADDR_CTRL, 8'h00, w);   // lands on the reload edge
    check_eq("ch1_coinc_edge", w, e + 161);
    wait_until(e + 200);

    // Channels 0/2/3 together; div=0 on ch2; ch0 div changed mid-count
    bus_write(ADDR_SEL, 8'h02, w);
    bus_write(ADDR_DIV, 8'h00, w);
    bus_write(ADDR_SEL, 8'h03, w);
    bus_write(ADDR_DIV, 8'h01, w);
    bus_write(ADDR_SEL, 8'h00, w);
    bus_write(ADDR_DIV, 8'h02, w);
    bus_write(ADDR_CTRL, 8'h0D, w);
    e = next_en1(w);
    for (int k = 0; k <= 9; k++) begin
      b = 4'b0100;
      if ((k % 2) == 0) b[3] = 1'b1;
      if (k == 0 || k == 3 || k == 9) b[0] = 1'b1;
      sb_q.push_back('{e + 1 + 16 * k, b});
    end
    wait_until(e + 20);
    bus_write(ADDR_DIV, 8'h05, w);
    wait_until(e + 145);

    // Asynchronous reset while channels are pulsing
    #2 core_rstn = 1'b0;
    #1;
    check_eq("async_ch",      {28'd0, ch_en_out}, 32'd0);
    check_eq("async_en1mhz",  {31'd0, en1mhz},    32'd0);
    check_eq("async_en16mhz", {31'd0, en16mhz},   32'd0);
    check_eq("async_en16_cs2",{31'd0, en16mhz_2}, 32'd0);
    repeat (3) @(negedge clk_cpu);
    #2 core_rstn = 1'b1;
    bus_read(ADDR_CTRL, 8'h00, "ctrl_post_rst");
    bus_read(ADDR_SEL,  8'h00, "sel_post_rst");
    bus_read(ADDR_DIV,  8'h00, "div_post_rst");
    wait_until(40);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xlr8_clken.md
XLR8_CLKEN -- requirements
Module: xlr8_clken

Interface
REQ-001 Parameter CLOCK_SELECT, default 0, sets clk_cpu rate: 0=16MHz, 1=32MHz, 2=64MHz; 3 is illegal.
REQ-002 Parameter NUM_CH, default 4, gives the number of programmable enable channels; legal range 1..8.
REQ-003 Parameter BASE_ADDR, default 8'hE0, gives the data-memory address of CTRL; SEL is at BASE_ADDR+1 and DIV at BASE_ADDR+2; BASE_ADDR >= 8'h60 and BASE_ADDR+2 <= 8'hFF.
REQ-004 clk_cpu  in  1  core clock; all flops are clocked on its rising edge.
REQ-005 core_rstn  in  1  reset, asynchronous, active-low.
REQ-006 ramadr  in  8  data-memory address.
REQ-007 ramre  in  1  read strobe.
REQ-008 ramwe  in  1  write strobe.
REQ-009 dm_sel  in  1  data-memory select; qualifies ramre and ramwe.
REQ-010 dbus_in  in  8  write data.
REQ-011 dbus_out  out  8  read data; 0 when no register of this block is read.
REQ-012 io_out_en  out  1  high while a register of this block is being read.
REQ-013 en1mhz  out  1  one-cycle pulse at 1MHz.
REQ-014 en16mhz  out  1  one-cycle pulse at 16MHz.
REQ-015 ch_en_out  out  NUM_CH  per-channel one-cycle enable pulses.

Function
REQ-016 Base counter: width W=CLOCK_SELECT+4; resets to 0.
  - When 0: reloads all-ones and registers en1mhz=1.
  - Otherwise: decrements and registers en1mhz=0.
  - en1mhz therefore pulses once every 2^W cycles, the first pulse on the first clock edge after reset release.
REQ-017 en16mhz:
  - CLOCK_SELECT=0: constant 1.
  - Otherwise: registered, high for one cycle whenever the base counter's low CLOCK_SELECT bits are all 0, i.e. once every 2^CLOCK_SELECT cycles.
REQ-018 Register access: a register is selected when dm_sel=1 and ramadr equals its address.
  - Write: on ramwe=1 at the clock edge.
  - Read: combinational; when ramre=1, dbus_out = register value and io_out_en=1.
REQ-019 CTRL: bits[NUM_CH-1:0] are the channel enables en[i], reset 0. Unused upper bits read 0 and ignore writes.
REQ-020 SEL: bits[2:0] channel index, reset 0. Upper bits read 0.
REQ-021 DIV: indirect access to div[SEL] (8 bits, reset 0 for every channel).
  - SEL >= NUM_CH: writes are ignored and reads return 0.
REQ-022 Each channel has an 8-bit counter cnt[i], reset 0. On every cycle with en1mhz=1 and en[i]=1:
  - cnt[i]==0: load div[i] and register ch_en_out[i]=1 for the next cycle.
  - Otherwise: cnt[i] decrements.
REQ-023 Channel timing: ch_en_out[i] period is (div[i]+1) en1mhz periods; the pulse lags en1mhz by exactly one cycle and is never longer than one cycle.
REQ-024 en[i]=0 forces cnt[i]=0 and ch_en_out[i]=0 on the next edge. Re-enabling therefore fires on the first en1mhz pulse after the enable.
REQ-025 A CTRL write that clears en[i] in the same cycle en1mhz=1: disable wins and no pulse is issued.
REQ-026 A DIV write in the same cycle as a reload of that channel: the reload uses the pre-write div value. A DIV write mid-count takes effect at the next reload and does not disturb the running count.
REQ-027 div=0 produces a pulse on every en1mhz.
REQ-028 Channels are independent; any number may pulse in the same cycle.

Reset
REQ-029 Asserting core_rstn low, including mid-count:
  - immediately clears all counters, CTRL, SEL and every div;
  - drives en1mhz, en16mhz and ch_en_out to 0.
  en16mhz returns to constant 1 on release when CLOCK_SELECT=0.
REQ-030 No state survives reset, and no output X is permitted after reset.

Verification
REQ-031 CLOCK_SELECT=0, release reset -> en1mhz high at cycles 1, 17, 33; en16mhz constantly 1.
REQ-032 CLOCK_SELECT=2 -> en1mhz every 64 cycles; en16mhz every 4 cycles, aligned to the base counter low bits = 0.
REQ-033 CLOCK_SELECT=0, SEL=0, DIV=4, CTRL=0x01 -> ch_en_out[0] pulses every 80 cycles, one cycle after en1mhz; other channels stay 0.
REQ-034 NUM_CH=4, SEL=7, write DIV=0x55 -> read DIV returns 0x00, read SEL returns 0x07, div[0..3] unchanged; io_out_en is high only on read cycles.
REQ-035 Channel 1 with DIV=9:
  - clear en[1] mid-count -> no pulse while disabled;
  - set en[1] -> pulse follows the next en1mhz;
  - clear en[1] coincident with en1mhz -> no pulse.
REQ-036 Assert core_rstn mid-count with 3 channels running -> all outputs 0 asynchronously; after release, CTRL, SEL and DIV read 0x00.
